// File: rtl/spi_master_arbiter_if.sv
// SPI_Master port group shared by the arbiter (controller side) and the SPI_Master core.
// Clients observe the status lines directly through the client modport.
interface spi_master_arbiter_if #(
  parameter int unsigned DataWidth = 8
);
  logic                 SPI_Write_o;
  logic                 SPI_ReadNext_o;
  logic [DataWidth-1:0] SPI_Data_o;
  logic                 SPI_CPOL_o;
  logic                 SPI_CPHA_o;
  logic                 SPI_LSBFE_o;
  logic                 SPI_Transmission_i;
  logic                 SPI_FIFOEmpty_i;
  logic                 SPI_FIFOFull_i;

  modport master (
    output SPI_Write_o, SPI_ReadNext_o, SPI_Data_o,
    output SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o,
    input  SPI_Transmission_i, SPI_FIFOEmpty_i
  );

  modport slave (
    input  SPI_Write_o, SPI_ReadNext_o, SPI_Data_o,
    input  SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o,
    output SPI_Transmission_i, SPI_FIFOEmpty_i, SPI_FIFOFull_i
  );

  modport client (
    input SPI_Transmission_i, SPI_FIFOEmpty_i, SPI_FIFOFull_i
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI_Master between two sensor FSMs, with
// per-grant timeout and a drain phase so transfers from the two clients never interleave.
module spi_master_arbiter #(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned TimerWidth = 16
) (
  input  logic                  Clk_i,
  input  logic                  Reset_i,
  input  logic                  Req0_i,
  input  logic                  Req1_i,
  output logic                  Gnt0_o,
  output logic                  Gnt1_o,
  input  logic                  C0_Write_i,
  input  logic                  C0_ReadNext_i,
  input  logic [DataWidth-1:0]  C0_Data_i,
  input  logic                  C0_CPOL_i,
  input  logic                  C0_CPHA_i,
  input  logic                  C0_LSBFE_i,
  input  logic                  C1_Write_i,
  input  logic                  C1_ReadNext_i,
  input  logic [DataWidth-1:0]  C1_Data_i,
  input  logic                  C1_CPOL_i,
  input  logic                  C1_CPHA_i,
  input  logic                  C1_LSBFE_i,
  input  logic [TimerWidth-1:0] TimeoutPreset_i,
  output logic                  Timeout_o,
  output logic                  TimeoutClient_o,
  spi_master_arbiter_if.master  spi
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [TimerWidth-1:0] cnt_q, cnt_d;
  logic                  blocked0_q, blocked0_d;
  logic                  blocked1_q, blocked1_d;
  logic                  timeout_q, timeout_d;
  logic                  tclient_q, tclient_d;
  logic [2:0]            mode_q, mode_d;
  logic                  gnt0_q, gnt1_q;
  logic                  elig0, elig1;

  assign elig0 = Req0_i & ~blocked0_q;
  assign elig1 = Req1_i & ~blocked1_q;

  // Next-state, grant bookkeeping and timeout/block tracking
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    blocked0_d = Req0_i ? blocked0_q : 1'b0;
    blocked1_d = Req1_i ? blocked1_q : 1'b0;
    timeout_d  = 1'b0;
    tclient_d  = tclient_q;
    mode_d     = mode_q;

    case (state_q)
      IDLE: begin
        if (elig0 && (!elig1 || last_gnt_q)) begin
          state_d    = GRANT0;
          last_gnt_d = 1'b0;
          cnt_d      = TimeoutPreset_i;
          mode_d     = {C0_CPOL_i, C0_CPHA_i, C0_LSBFE_i};
        end else if (elig1) begin
          state_d    = GRANT1;
          last_gnt_d = 1'b1;
          cnt_d      = TimeoutPreset_i;
          mode_d     = {C1_CPOL_i, C1_CPHA_i, C1_LSBFE_i};
        end
      end
      GRANT0: begin
        if (!Req0_i) begin
          state_d = DRAIN;
        end else if (cnt_q == TimerWidth'(1)) begin
          state_d    = DRAIN;
          timeout_d  = 1'b1;
          tclient_d  = 1'b0;
          blocked0_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - TimerWidth'(1);
        end
      end
      GRANT1: begin
        if (!Req1_i) begin
          state_d = DRAIN;
        end else if (cnt_q == TimerWidth'(1)) begin
          state_d    = DRAIN;
          timeout_d  = 1'b1;
          tclient_d  = 1'b1;
          blocked1_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - TimerWidth'(1);
        end
      end
      DRAIN: begin
        if (!spi.SPI_Transmission_i && spi.SPI_FIFOEmpty_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any grant immediately; no drain is performed
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      blocked0_q <= 1'b0;
      blocked1_q <= 1'b0;
      timeout_q  <= 1'b0;
      tclient_q  <= 1'b0;
      mode_q     <= 3'b000;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      blocked0_q <= blocked0_d;
      blocked1_q <= blocked1_d;
      timeout_q  <= timeout_d;
      tclient_q  <= tclient_d;
      mode_q     <= mode_d;
      gnt0_q     <= (state_d == GRANT0);
      gnt1_q     <= (state_d == GRANT1);
    end
  end

  assign Gnt0_o          = gnt0_q;
  assign Gnt1_o          = gnt1_q;
  assign Timeout_o       = timeout_q;
  assign TimeoutClient_o = tclient_q;

  // Strobes of the non-owner are dropped, never queued
  assign spi.SPI_Write_o    = (C0_Write_i & gnt0_q) | (C1_Write_i & gnt1_q);
  assign spi.SPI_ReadNext_o = (C0_ReadNext_i & gnt0_q) | (C1_ReadNext_i & gnt1_q);
  assign spi.SPI_Data_o     = gnt0_q ? C0_Data_i : (gnt1_q ? C1_Data_i : '0);
  assign spi.SPI_CPOL_o     = mode_q[2];
  assign spi.SPI_CPHA_o     = mode_q[1];
  assign spi.SPI_LSBFE_o    = mode_q[0];

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: grant latency, muxing, round-robin,
// drain, timeout/blocking, disabled timeout and reset abort.
module tb_spi_master_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned TW = 16;

  logic          clk;
  logic          rst;
  logic          req0, req1;
  logic          gnt0, gnt1;
  logic          c0_wr, c0_rn, c0_cpol, c0_cpha, c0_lsbfe;
  logic          c1_wr, c1_rn, c1_cpol, c1_cpha, c1_lsbfe;
  logic [DW-1:0] c0_data, c1_data;
  logic [TW-1:0] preset;
  logic          tout, tclient;

  int checks = 0;
  int errors = 0;

  spi_master_arbiter_if #(.DataWidth(DW)) spi ();

  spi_master_arbiter #(.DataWidth(DW), .TimerWidth(TW)) dut (
    .Clk_i          (clk),
    .Reset_i        (rst),
    .Req0_i         (req0),
    .Req1_i         (req1),
    .Gnt0_o         (gnt0),
    .Gnt1_o         (gnt1),
    .C0_Write_i     (c0_wr),
    .C0_ReadNext_i  (c0_rn),
    .C0_Data_i      (c0_data),
    .C0_CPOL_i      (c0_cpol),
    .C0_CPHA_i      (c0_cpha),
    .C0_LSBFE_i     (c0_lsbfe),
    .C1_Write_i     (c1_wr),
    .C1_ReadNext_i  (c1_rn),
    .C1_Data_i      (c1_data),
    .C1_CPOL_i      (c1_cpol),
    .C1_CPHA_i      (c1_cpha),
    .C1_LSBFE_i     (c1_lsbfe),
    .TimeoutPreset_i(preset),
    .Timeout_o      (tout),
    .TimeoutClient_o(tclient),
    .spi            (spi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic any_drop;
  logic any_tout;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    c0_wr = 1'b0; c0_rn = 1'b0; c0_data = '0; c0_cpol = 1'b0; c0_cpha = 1'b0; c0_lsbfe = 1'b0;
    c1_wr = 1'b0; c1_rn = 1'b0; c1_data = '0; c1_cpol = 1'b0; c1_cpha = 1'b0; c1_lsbfe = 1'b0;
    preset = '0;
    spi.SPI_Transmission_i = 1'b0;
    spi.SPI_FIFOEmpty_i    = 1'b1;
    spi.SPI_FIFOFull_i     = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_tout", 32'(tout), 32'd0);
    chk("rst_tclient", 32'(tclient), 32'd0);
    chk("rst_cpol", 32'(spi.SPI_CPOL_o), 32'd0);
    chk("rst_wr", 32'(spi.SPI_Write_o), 32'd0);

    // Single request, latency 1, mode latch and data mux
    req0 = 1'b1; c0_cpha = 1'b1; c0_lsbfe = 1'b1;
    tick();
    chk("t1_gnt0", 32'(gnt0), 32'd1);
    chk("t1_gnt1", 32'(gnt1), 32'd0);
    chk("t1_cpha", 32'(spi.SPI_CPHA_o), 32'd1);
    chk("t1_lsbfe", 32'(spi.SPI_LSBFE_o), 32'd1);
    c0_data = 8'hA5; c0_wr = 1'b1; c0_rn = 1'b1;
    #1;
    chk("t1_data", 32'(spi.SPI_Data_o), 32'hA5);
    chk("t1_wr", 32'(spi.SPI_Write_o), 32'd1);
    chk("t1_rn", 32'(spi.SPI_ReadNext_o), 32'd1);
    c0_wr = 1'b0; c0_rn = 1'b0; c1_wr = 1'b1; c1_data = 8'h3C;
    #1;
    chk("t1_c1wr_ignored", 32'(spi.SPI_Write_o), 32'd0);
    chk("t1_c1data_ignored", 32'(spi.SPI_Data_o), 32'hA5);
    c1_wr = 1'b0; c0_cpha = 1'b0; c0_lsbfe = 1'b0;
    req0 = 1'b0;
    tick();
    chk("t1_drain_gnt0", 32'(gnt0), 32'd0);
    chk("t1_drain_data", 32'(spi.SPI_Data_o), 32'd0);
    tick(); tick();
    chk("t1_cpha_hold", 32'(spi.SPI_CPHA_o), 32'd1);

    // Simultaneous requests from reset, then round-robin
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("t2_gnt0_first", 32'(gnt0), 32'd1);
    chk("t2_gnt1_wait", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    tick();
    chk("t2_drain_gnt0", 32'(gnt0), 32'd0);
    chk("t2_drain_gnt1", 32'(gnt1), 32'd0);
    tick();
    chk("t2_idle_gnt1", 32'(gnt1), 32'd0);
    tick();
    chk("t2_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    tick(); tick();
    chk("t2_rel_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("t2_rr_gnt0", 32'(gnt0), 32'd1);
    chk("t2_rr_gnt1", 32'(gnt1), 32'd0);

    // Drain holds off the waiting client while the SPI master is busy
    req0 = 1'b0; spi.SPI_Transmission_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t3_busy_gnt1_%0d", i), 32'(gnt1), 32'd0);
    end
    spi.SPI_Transmission_i = 1'b0;
    tick();
    chk("t3_idle_gnt1", 32'(gnt1), 32'd0);
    tick();
    chk("t3_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    tick(); tick();

    // Timeout of client 1 with preset 4, blocking and re-grant
    preset = 16'd4; c1_cpol = 1'b1; req1 = 1'b1;
    tick();
    chk("t4_gnt1_c1", 32'(gnt1), 32'd1);
    chk("t4_cpol", 32'(spi.SPI_CPOL_o), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("t4_gnt1_c%0d", i), 32'(gnt1), 32'd1);
      chk($sformatf("t4_notout_c%0d", i), 32'(tout), 32'd0);
    end
    tick();
    chk("t4_gnt1_revoked", 32'(gnt1), 32'd0);
    chk("t4_tout_pulse", 32'(tout), 32'd1);
    chk("t4_tclient", 32'(tclient), 32'd1);
    tick();
    chk("t4_tout_low", 32'(tout), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t4_blocked_%0d", i), 32'(gnt1), 32'd0);
    end
    chk("t4_cpol_hold", 32'(spi.SPI_CPOL_o), 32'd1);
    req1 = 1'b0;
    tick();
    req1 = 1'b1;
    tick();
    chk("t4_regrant", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    tick(); tick();

    // Release on the expiry cycle is a normal release
    preset = 16'd2; req0 = 1'b1;
    tick();
    chk("t5_gnt0", 32'(gnt0), 32'd1);
    tick();
    chk("t5_gnt0_last", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    tick();
    chk("t5_rel_gnt0", 32'(gnt0), 32'd0);
    chk("t5_no_tout", 32'(tout), 32'd0);
    chk("t5_tclient_keep", 32'(tclient), 32'd1);
    tick(); tick();

    // Timeout disabled
    preset = '0; req0 = 1'b1;
    any_drop = 1'b0; any_tout = 1'b0;
    tick();
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (gnt0 !== 1'b1) any_drop = 1'b1;
      if (tout !== 1'b0) any_tout = 1'b1;
    end
    chk("t6_gnt0_held", 32'(gnt0), 32'd1);
    chk("t6_never_dropped", 32'(any_drop), 32'd0);
    chk("t6_never_timeout", 32'(any_tout), 32'd0);
    req0 = 1'b0;
    tick(); tick();

    // Reset in the middle of a client-1 grant
    c1_cpol = 1'b1; req1 = 1'b1;
    tick();
    chk("t7_gnt1", 32'(gnt1), 32'd1);
    chk("t7_cpol", 32'(spi.SPI_CPOL_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_gnt1", 32'(gnt1), 32'd0);
    chk("t7_rst_cpol", 32'(spi.SPI_CPOL_o), 32'd0);
    chk("t7_rst_tclient", 32'(tclient), 32'd0);
    req0 = 1'b1;
    tick();
    chk("t7_tie_gnt0", 32'(gnt0), 32'd1);
    chk("t7_tie_gnt1", 32'(gnt1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
